layer_seq_ctrl: RTL and testbench

Per-layer sequencer that answers the model controller's ln_start pulse. On each kick it runs the five sub-blocks of one transformer layer in order (LN1, ATTN, LN2, FFN1, FFN2), issuing a one-cycle start pulse to each and waiting for that block's done pulse. When FFN2 finishes it returns a one-cycle linear2_done to the model controller. It tracks the layer index and publishes the per-layer weight base address, and flags stalled sub-blocks with a watchdog.

---
 rtl/layer_seq_ctrl.sv | 119 +++++++++++
 tb/tb_layer_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// rtl/layer_seq_ctrl.sv - per-layer sequencer: LN1, ATTN, LN2, FFN1, FFN2 start/done handshakes
// with layer index, weight base address and a per-stage watchdog.
module layer_seq_ctrl #(
  parameter int                NUM_LAYER    = 12,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] LAYER_STRIDE = ADDR_W'(32'h0001_0000),
  parameter int                TIMEOUT      = 65535,
  localparam int               IDX_W        = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ln_start,
  input  logic              ln1_done,
  input  logic              attn_done,
  input  logic              ln2_done,
  input  logic              ffn1_done,
  input  logic              ffn2_done,
  output logic              ln1_start,
  output logic              attn_start,
  output logic              ln2_start,
  output logic              ffn1_start,
  output logic              ffn2_start,
  output logic              linear2_done,
  output logic              busy,
  output logic [IDX_W-1:0]  layer_idx,
  output logic [ADDR_W-1:0] wbase,
  output logic              err
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Watchdog fires on the edge that would complete the TIMEOUT-th cycle in a stage.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LN1, S_ATTN, S_LN2, S_FFN1, S_FFN2, S_ERR
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             stage_done;

  always_comb begin
    stage_done = 1'b0;
    case (state)
      S_LN1:   stage_done = ln1_done;
      S_ATTN:  stage_done = attn_done;
      S_LN2:   stage_done = ln2_done;
      S_FFN1:  stage_done = ffn1_done;
      S_FFN2:  stage_done = ffn2_done;
      default: stage_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      ln1_start    <= 1'b0;
      attn_start   <= 1'b0;
      ln2_start    <= 1'b0;
      ffn1_start   <= 1'b0;
      ffn2_start   <= 1'b0;
      linear2_done <= 1'b0;
      busy         <= 1'b0;
      layer_idx    <= '0;
      wbase        <= '0;
      err          <= 1'b0;
    end else begin
      ln1_start    <= 1'b0;
      attn_start   <= 1'b0;
      ln2_start    <= 1'b0;
      ffn1_start   <= 1'b0;
      ffn2_start   <= 1'b0;
      linear2_done <= 1'b0;
      // wbase trails layer_idx by one cycle by construction.
      wbase        <= ADDR_W'(layer_idx) * LAYER_STRIDE;

      case (state)
        S_IDLE: begin
          if (ln_start) begin
            state     <= S_LN1;
            ln1_start <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
          end
        end
        S_ERR: begin
        end
        default: begin
          if (ln_start)
            err <= 1'b1;
          if (stage_done) begin
            timer <= '0;
            case (state)
              S_LN1:  begin state <= S_ATTN; attn_start <= 1'b1; end
              S_ATTN: begin state <= S_LN2;  ln2_start  <= 1'b1; end
              S_LN2:  begin state <= S_FFN1; ffn1_start <= 1'b1; end
              S_FFN1: begin state <= S_FFN2; ffn2_start <= 1'b1; end
              default: begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                linear2_done <= 1'b1;
                layer_idx    <= (layer_idx == IDX_LAST) ? '0 : layer_idx + 1'b1;
              end
            endcase
          end else if (TIMEOUT != 0 && timer == TMR_LAST) begin
            state <= S_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb/tb_layer_seq_ctrl.sv - self-checking bench for layer_seq_ctrl: vector table,
// directed corner sequences and random traffic against a stage-level reference model.
module tb_layer_seq_ctrl;

  localparam int          NL     = 12;
  localparam int          TMO    = 8;
  localparam logic [31:0] STRIDE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ln_start = 1'b0;
  logic [4:0]  dn = '0;
  logic        ln1_done, attn_done, ln2_done, ffn1_done, ffn2_done;
  logic        ln1_start, attn_start, ln2_start, ffn1_start, ffn2_start;
  logic        linear2_done, busy, err;
  logic [3:0]  layer_idx;
  logic [31:0] wbase;
  logic [4:0]  st_o;

  assign {ffn2_done, ffn1_done, ln2_done, attn_done, ln1_done} = dn;
  assign st_o = {ffn2_start, ffn1_start, ln2_start, attn_start, ln1_start};

  always #5 clk = ~clk;

  layer_seq_ctrl #(.NUM_LAYER(NL), .ADDR_W(32), .LAYER_STRIDE(STRIDE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ln_start(ln_start),
    .ln1_done(ln1_done), .attn_done(attn_done), .ln2_done(ln2_done),
    .ffn1_done(ffn1_done), .ffn2_done(ffn2_done),
    .ln1_start(ln1_start), .attn_start(attn_start), .ln2_start(ln2_start),
    .ffn1_start(ffn1_start), .ffn2_start(ffn2_start),
    .linear2_done(linear2_done), .busy(busy), .layer_idx(layer_idx),
    .wbase(wbase), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: m_stage 0 = idle, 1..5 = waiting on done[m_stage-1], -1 = dead.
  int          m_stage, m_age, m_idx;
  logic        m_err, m_l2d, m_busy;
  logic [4:0]  m_starts;
  logic [31:0] m_wbase;

  task automatic model_reset();
    m_stage = 0; m_age = 0; m_idx = 0; m_err = 0;
    m_l2d = 0; m_busy = 0; m_starts = '0; m_wbase = '0;
  endtask

  task automatic model_step(input logic ln, input logic [4:0] d);
    m_wbase  = m_idx * STRIDE;
    m_starts = '0;
    m_l2d    = 0;
    if (m_stage == 0) begin
      if (ln) begin m_stage = 1; m_age = 0; m_starts = 5'b00001; end
    end else if (m_stage > 0) begin
      if (ln) m_err = 1;
      if (d[m_stage-1]) begin
        if (m_stage == 5) begin
          m_stage = 0; m_l2d = 1; m_idx = (m_idx + 1) % NL;
        end else begin
          m_starts = 5'(1 << m_stage); m_stage++; m_age = 0;
        end
      end else begin
        m_age++;
        if (m_age == TMO) begin m_stage = -1; m_err = 1; end
      end
    end
    m_busy = (m_stage > 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    check("outputs", 32'({st_o, linear2_done, busy, err}), 32'({m_starts, m_l2d, m_busy, m_err}));
    check("layer_idx", 32'(layer_idx), 32'(m_idx));
    check("wbase", wbase, m_wbase);
  endtask

  task automatic cycle();
    model_step(ln_start, dn);
    @(posedge clk); #1;
    cyc++;
    compare_all();
    ln_start = 0;
    dn = '0;
  endtask

  task automatic do_reset();
    reset_n = 0; ln_start = 0; dn = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; cyc++;
      compare_all();
    end
    reset_n = 1;
  endtask

  typedef struct {
    logic       ln;
    logic [4:0] d;
    logic [4:0] st;
    logic       l2d;
    logic       bsy;
    logic       er;
    int         idx;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int t0, kicks, l2d_cnt, ln2_cyc, err_cyc, pulses;
    int seen[6];

    // Stray dones, repeated done, done in start cycle, protocol error in ATTN.
    tbl[0]  = '{1'b1, 5'b00000, 5'b00001, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 5'b10010, 5'b00000, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 5'b00001, 5'b00010, 1'b0, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 5'b00001, 5'b00000, 1'b0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 5'b00010, 5'b00100, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 5'b00100, 5'b01000, 1'b0, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b0, 5'b01000, 5'b10000, 1'b0, 1'b1, 1'b0, 0};
    tbl[7]  = '{1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 5'b00001, 5'b00001, 1'b0, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b0, 5'b00001, 5'b00010, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b1, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b0, 5'b00010, 5'b00100, 1'b0, 1'b1, 1'b1, 1};
    tbl[12] = '{1'b0, 5'b00100, 5'b01000, 1'b0, 1'b1, 1'b1, 1};
    tbl[13] = '{1'b0, 5'b01000, 5'b10000, 1'b0, 1'b1, 1'b1, 1};
    tbl[14] = '{1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0, 1'b1, 2};

    // Reset state.
    do_reset();
    check("reset_outputs", 32'({st_o, linear2_done, busy, err}), 32'h0);
    cycle();
    check("no_pulse_after_reset", 32'({st_o, linear2_done}), 32'h0);

    // Vector table.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      ln_start = tbl[i].ln;
      dn = tbl[i].d;
      cycle();
      check("tbl_outputs", 32'({st_o, linear2_done, busy, err}),
            32'({tbl[i].st, tbl[i].l2d, tbl[i].bsy, tbl[i].er}));
      check("tbl_idx", 32'(layer_idx), 32'(tbl[i].idx));
    end

    // Single layer, every done returned 4 cycles after its start.
    do_reset();
    for (int s = 0; s < 6; s++) seen[s] = -1;
    t0 = -100;
    for (int k = 0; k < 45; k++) begin
      if (k == 5) begin ln_start = 1; t0 = cyc; end
      for (int s = 0; s < 5; s++)
        if (seen[s] >= 0 && cyc == seen[s] + 4) dn[s] = 1'b1;
      cycle();
      for (int s = 0; s < 5; s++)
        if (st_o[s] && seen[s] < 0) seen[s] = cyc;
      if (linear2_done && seen[5] < 0) seen[5] = cyc;
      if (cyc == t0 + 26) check("single_idx", 32'(layer_idx), 32'd1);
      if (cyc == t0 + 27) check("single_wbase", wbase, 32'h0001_0000);
    end
    for (int s = 0; s < 5; s++) check("single_start_time", 32'(seen[s] - t0), 32'(1 + 5 * s));
    check("single_l2d_time", 32'(seen[5] - t0), 32'd26);

    // Back-to-back with immediate dones; twelve kicks wrap the index.
    do_reset();
    kicks = 0; l2d_cnt = 0; t0 = 0;
    for (int k = 0; k < 200 && l2d_cnt < 12; k++) begin
      if (m_stage == 0 && kicks < 12) begin
        ln_start = 1; kicks++;
        if (kicks == 1) t0 = cyc;
      end
      if (m_stage > 0) dn[m_stage-1] = 1'b1;
      cycle();
      if (linear2_done) begin
        l2d_cnt++;
        if (l2d_cnt == 1) check("b2b_latency", 32'(cyc - t0), 32'd6);
      end
    end
    check("b2b_count", 32'(l2d_cnt), 32'd12);
    check("b2b_idx_wrap", 32'(layer_idx), 32'd0);
    cycle();
    check("b2b_wbase_wrap", wbase, 32'h0);
    check("b2b_err", 32'(err), 32'd0);

    // Watchdog: LN2 done withheld.
    do_reset();
    ln_start = 1; cycle();
    dn = 5'b00001; cycle();
    dn = 5'b00010; cycle();
    ln2_cyc = cyc; err_cyc = -1;
    check("wd_ln2_start", 32'(ln2_start), 32'd1);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (err && err_cyc < 0) err_cyc = cyc;
    end
    check("wd_err_time", 32'(err_cyc - ln2_cyc), 32'd8);
    check("wd_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      ln_start = 1; dn = 5'h1f;
      cycle();
      pulses += int'($countones({st_o, linear2_done}));
    end
    check("wd_dead_pulses", 32'(pulses), 32'd0);
    check("wd_err_sticky", 32'(err), 32'd1);

    // Asynchronous reset in FFN1 after one completed layer.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (m_stage == 0 && k == 0) ln_start = 1;
      if (m_stage > 0) dn[m_stage-1] = 1'b1;
      cycle();
    end
    ln_start = 1; cycle();
    dn = 5'b00001; cycle();
    dn = 5'b00010; cycle();
    dn = 5'b00100; cycle();
    check("pre_reset_ffn1", 32'({ffn1_start, layer_idx}), 32'h11);
    #2 reset_n = 0;
    #1 model_reset();
    compare_all();
    check("async_reset_zero", 32'({st_o, linear2_done, busy, err, layer_idx}), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; cyc++;
      compare_all();
    end
    reset_n = 1;
    cycle();
    ln_start = 1; cycle();
    check("restart_ln1", 32'(st_o), 32'h1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (m_stage < 0 || (m_err && $urandom_range(0, 15) == 0)) begin
        do_reset();
      end else begin
        ln_start = ($urandom_range(0, 5) == 0);
        if (m_stage > 0 && $urandom_range(0, 2) == 0) dn[m_stage-1] = 1'b1;
        if ($urandom_range(0, 9) == 0) dn = dn | 5'($urandom);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
